matrix_result_collector: RTL and testbench

- Downstream stage of the sequential matrix multiplier.
- Consumes its result stream: z_out, z_i, z_j with the z_stb/z_ack handshake.
- Stores each word in an M x M result register array. A later partial-sum write to the same cell overwrites the earlier one, so the final write per cell leaves the completed dot product.
- On the multiplier's done pulse, streams the full matrix out row-major over a valid/ready port for the next consumer (host readback or the next matrix stage).

---
 rtl/matrix_result_collector_pkg.sv | 21 ++
 rtl/matrix_result_collector_regfile.sv | 50 +++++
 rtl/matrix_result_collector.sv | 149 ++++++++++++++
 tb/tb_matrix_result_collector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_result_collector_pkg.sv
// Shared definitions for the matrix result collector and its register file.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package matrix_result_collector_pkg;

    // Widths shared with the sequential matrix multiplier.
    localparam int W     = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    // Row/column pointer width for an M x M array; at least one bit so M = 1 still has a port.
    function automatic int ptr_w(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/matrix_result_collector_regfile.sv
// M x M result register array with a written-cell map; unwritten cells read as zero.
// Latency: write lands on the next clk edge; read port is combinational.
// Backpressure: none; every write request is taken.
// Ports: clk/rst (async high, resets the written map only), i_clr clears the map,
//        i_we/i_wr_row/i_wr_col/i_wr_data write port, i_rd_row/i_rd_col -> o_rd_data read port.
module result_regfile #(
    parameter int M     = 4,
    parameter int W     = matrix_result_collector_pkg::W,
    parameter int PTR_W = matrix_result_collector_pkg::ptr_w(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_wr_row,
    input  logic [PTR_W-1:0] i_wr_col,
    input  logic [W-1:0]     i_wr_data,
    input  logic [PTR_W-1:0] i_rd_row,
    input  logic [PTR_W-1:0] i_rd_col,
    output logic [W-1:0]     o_rd_data
);
    import matrix_result_collector_pkg::*;

    logic [W-1:0]          r_mem [M][M];
    logic [M-1:0][M-1:0]   r_written;

    // Data cells carry no reset; the written map decides whether they are visible.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    // A write in the same cycle as a clear survives: the clear is applied first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_written <= '0;
        end else begin
            if (i_clr) begin
                r_written <= '0;
            end
            if (i_we) begin
                r_written[i_wr_row][i_wr_col] <= 1'b1;
            end
        end
    end

    assign o_rd_data = r_written[i_rd_row][i_rd_col] ? r_mem[i_rd_row][i_rd_col] : '0;

endmodule

// File: rtl/matrix_result_collector.sv
// Collects the multiplier's (row, col, word) result stream into an M x M array and drains it row-major.
// Latency: z_stb -> z_ack one edge; mm_done -> first drain word one edge; 1 word/cycle drain.
// Backpressure: drain holds out_stb/out_data stable until out_ack; results are acked one per strobe.
// Ports: clk/rst (async high); start arms collection; z_out/z_i/z_j/z_stb/z_ack result input;
//        mm_done triggers drain; out_data/out_row/out_col/out_stb/out_ack/out_last drain port;
//        busy while collecting or draining; idx_err sticky out-of-range index flag.
module matrix_result_collector #(
    parameter int M     = 4,
    parameter int W     = matrix_result_collector_pkg::W,
    parameter int IDX_W = matrix_result_collector_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     z_out,
    input  logic [IDX_W-1:0] z_i,
    input  logic [IDX_W-1:0] z_j,
    input  logic             z_stb,
    output logic             z_ack,
    input  logic             mm_done,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             out_stb,
    input  logic             out_ack,
    output logic             out_last,
    output logic             busy,
    output logic             idx_err
);
    import matrix_result_collector_pkg::*;

    localparam int               PTR_W    = ptr_w(M);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(M - 1);

    state_t           r_state;
    logic             r_z_ack;
    logic             r_out_stb;
    logic             r_out_last;
    logic             r_busy;
    logic             r_idx_err;
    logic [PTR_W-1:0] r_row;
    logic [PTR_W-1:0] r_col;

    logic             w_in_range;
    logic             w_accept;
    logic             w_we;
    logic [W-1:0]     w_rd_data;

    assign w_in_range = (int'(z_i) < M) && (int'(z_j) < M);
    // The ack cycle blocks re-acceptance, so the strobe still high during the ack is not a second word.
    assign w_accept   = (r_state == S_COLLECT) && z_stb && !r_z_ack;
    assign w_we       = w_accept && w_in_range;

    result_regfile #(
        .M     (M),
        .W     (W),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (start),
        .i_we      (w_we),
        .i_wr_row  (z_i[PTR_W-1:0]),
        .i_wr_col  (z_j[PTR_W-1:0]),
        .i_wr_data (z_out),
        .i_rd_row  (r_row),
        .i_rd_col  (r_col),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_z_ack    <= 1'b0;
            r_out_stb  <= 1'b0;
            r_out_last <= 1'b0;
            r_busy     <= 1'b0;
            r_idx_err  <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
        end else begin
            // A pending ack completes regardless of any state change this cycle.
            r_z_ack <= w_accept;

            // A fresh error in the same cycle as start wins over the clear.
            if (start) begin
                r_idx_err <= 1'b0;
            end
            if (w_accept && !w_in_range) begin
                r_idx_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COLLECT;
                        r_busy  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    // start restarts collection in place and takes priority over done.
                    if (!start && mm_done) begin
                        r_state    <= S_DRAIN;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_out_stb  <= 1'b1;
                        r_out_last <= (M == 1);
                    end
                end
                S_DRAIN: begin
                    if (start) begin
                        r_state    <= S_COLLECT;
                        r_out_stb  <= 1'b0;
                        r_out_last <= 1'b0;
                    end else if (out_ack) begin
                        if (r_out_last) begin
                            r_state    <= S_IDLE;
                            r_out_stb  <= 1'b0;
                            r_out_last <= 1'b0;
                            r_busy     <= 1'b0;
                        end else if (r_col == LAST_IDX) begin
                            // Next word starts a row at column 0; only final when M = 1, handled above.
                            r_col      <= '0;
                            r_row      <= r_row + PTR_W'(1);
                            r_out_last <= 1'b0;
                        end else begin
                            r_col      <= r_col + PTR_W'(1);
                            r_out_last <= (r_row == LAST_IDX) && ((r_col + PTR_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign z_ack    = r_z_ack;
    assign out_stb  = r_out_stb;
    assign out_last = r_out_last;
    assign busy     = r_busy;
    assign idx_err  = r_idx_err;
    // Drain outputs read as zero whenever no word is being presented.
    assign out_data = r_out_stb ? w_rd_data : '0;
    assign out_row  = r_out_stb ? IDX_W'(r_row) : '0;
    assign out_col  = r_out_stb ? IDX_W'(r_col) : '0;

endmodule

// File: tb/tb_matrix_result_collector.sv
// Directed bench for matrix_result_collector with M = 4.
// Latency: n/a.
// Backpressure: exercised by toggling out_ack during drains.
module tb_matrix_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] z_out = '0;
    logic [4:0]  z_i = '0;
    logic [4:0]  z_j = '0;
    logic        z_stb = 1'b0;
    logic        z_ack;
    logic        mm_done = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_row;
    logic [4:0]  out_col;
    logic        out_stb;
    logic        out_ack = 1'b0;
    logic        out_last;
    logic        busy;
    logic        idx_err;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_mem [16];

    matrix_result_collector #(.M(4), .W(32), .IDX_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .z_out    (z_out),
        .z_i      (z_i),
        .z_j      (z_j),
        .z_stb    (z_stb),
        .z_ack    (z_ack),
        .mm_done  (mm_done),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_stb  (out_stb),
        .out_ack  (out_ack),
        .out_last (out_last),
        .busy     (busy),
        .idx_err  (idx_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One result word, with the strobe held through the ack cycle like the multiplier does.
    task automatic wr(input logic [4:0] i, input logic [4:0] j, input logic [31:0] d);
        z_i   = i;
        z_j   = j;
        z_out = d;
        z_stb = 1'b1;
        tick();
        chk("ack_rise", {63'b0, z_ack}, 64'd1);
        tick();
        z_stb = 1'b0;
        chk("ack_fall", {63'b0, z_ack}, 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
    endtask

    function automatic logic [63:0] word_exp(input int k);
        logic [4:0] r;
        logic [4:0] c;
        r = 5'(k / 4);
        c = 5'(k % 4);
        return {20'b0, 1'b1, r, c, (k == 15), exp_mem[k]};
    endfunction

    function automatic logic [63:0] word_obs();
        return {20'b0, out_stb, out_row, out_col, out_last, out_data};
    endfunction

    // Full drain of 16 words; with toggle set every transfer is followed by a stall cycle.
    task automatic drain(input bit toggle);
        for (int k = 0; k < 16; k++) begin
            out_ack = 1'b1;
            chk("drain_word", word_obs(), word_exp(k));
            tick();
            if (toggle && k < 15) begin
                out_ack = 1'b0;
                chk("drain_hold", word_obs(), word_exp(k + 1));
                tick();
            end
        end
        out_ack = 1'b0;
        chk("drain_end_stb", {63'b0, out_stb}, 64'd0);
        chk("drain_end_busy", {63'b0, busy}, 64'd0);
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 16; k++) begin
            exp_mem[k] = '0;
        end
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        chk("rst_outputs", {52'b0, z_ack, out_stb, out_last, busy, idx_err, out_row, out_col},
            64'd0);
        chk("rst_data", {32'b0, out_data}, 64'd0);
        rst = 1'b0;

        // Strobes and done in S_IDLE are ignored.
        z_stb = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("idle_no_ack", {63'b0, z_ack}, 64'd0);
        end
        z_stb = 1'b0;
        pulse_done();
        chk("idle_done_ignored", {62'b0, out_stb, busy}, 64'd0);

        // Single write then full drain.
        pulse_start();
        chk("busy_collect", {63'b0, busy}, 64'd1);
        wr(5'd1, 5'd2, 32'h4040_0000);
        pulse_done();
        clear_exp();
        exp_mem[6] = 32'h4040_0000;
        drain(1'b0);

        // Last of three writes to one cell wins; stale (1,2) hidden by the map clear; stalled drain.
        pulse_start();
        wr(5'd0, 5'd0, 32'h3F80_0000);
        wr(5'd0, 5'd0, 32'h4000_0000);
        wr(5'd0, 5'd0, 32'h4040_0000);
        pulse_done();
        clear_exp();
        exp_mem[0] = 32'h4040_0000;
        drain(1'b1);

        // Out-of-range row: acked, flagged, nothing written.
        pulse_start();
        wr(5'd5, 5'd0, 32'hDEAD_BEEF);
        chk("idx_err_set", {63'b0, idx_err}, 64'd1);
        pulse_done();
        clear_exp();
        drain(1'b0);
        chk("idx_err_sticky", {63'b0, idx_err}, 64'd1);
        pulse_start();
        chk("idx_err_cleared", {63'b0, idx_err}, 64'd0);

        // Abort a drain with start after three words.
        wr(5'd2, 5'd3, 32'h1234_5678);
        pulse_done();
        clear_exp();
        exp_mem[11] = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            out_ack = 1'b1;
            chk("abort_pre_word", word_obs(), word_exp(k));
            tick();
        end
        out_ack = 1'b0;
        pulse_start();
        chk("abort_stb_low", {63'b0, out_stb}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd1);
        pulse_done();
        clear_exp();
        drain(1'b0);

        // Asynchronous reset in the middle of a drain.
        pulse_start();
        wr(5'd3, 5'd3, 32'hCAFE_F00D);
        pulse_done();
        out_ack = 1'b1;
        tick();
        tick();
        out_ack = 1'b0;
        chk("pre_rst_stb", {63'b0, out_stb}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {52'b0, z_ack, out_stb, out_last, busy, idx_err, out_row, out_col},
            64'd0);
        chk("async_rst_data", {32'b0, out_data}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", {62'b0, out_stb, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
